// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 mux among four requesters; the selected
// word is registered and handed downstream with valid/ready, then acknowledged.

module mux4x1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] f0,
    input  logic [WIDTH-1:0] f1,
    input  logic [WIDTH-1:0] f2,
    input  logic [WIDTH-1:0] f3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        unique case (s)
            2'd0:    y = f0;
            2'd1:    y = f1;
            2'd2:    y = f2;
            default: y = f3;
        endcase
    end
endmodule

module mux_rr_scheduler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic             out_ready,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       ack,
    output logic             busy
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       winner;
    logic             found;
    logic [1:0]       sel_nxt;
    logic [WIDTH-1:0] mux_y;

    // Search starts at ptr; the 2-bit add wraps 3 back to 0.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[ptr_q + 2'(k)]) begin
                winner = ptr_q + 2'(k);
                found  = 1'b1;
            end
        end
    end

    assign sel_nxt = (state_q == IDLE) ? winner : sel_q;

    mux4x1 #(.WIDTH(WIDTH)) u_mux (
        .f0 (data0),
        .f1 (data1),
        .f2 (data2),
        .f3 (data3),
        .s  (sel_nxt),
        .y  (mux_y)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d       = winner;
                    out_data_d  = mux_y;
                    out_valid_d = 1'b1;
                    state_d     = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    ptr_d       = sel_q + 2'd1;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // The only ack path: the word is transferred when valid meets ready.
    assign ack       = (out_valid_q && out_ready) ? (4'b0001 << sel_q) : 4'b0000;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == SEND);
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Bench for mux_rr_scheduler: directed scenarios plus random traffic, all checked
// against a transaction-level round-robin model.

module tb_mux_rr_scheduler;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     req = 4'b0000;
    logic [W-1:0]   d[4];
    logic           out_ready = 1'b0;
    logic [1:0]     sel;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [3:0]     ack;
    logic           busy;

    mux_rr_scheduler #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (d[0]),
        .data1     (d[1]),
        .data2     (d[2]),
        .data3     (d[3]),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Model: is a word held for downstream, whose is it, and where the search starts.
    bit         m_busy = 1'b0;
    int         m_sel  = 0;
    int         m_ptr  = 0;
    logic [W-1:0] m_data = '0;

    wire [W+7:0] dut_vec = {out_valid, busy, sel, out_data, ack};

    function automatic logic [W+7:0] exp_vec();
        logic [3:0] a;
        logic [1:0] s;
        s = m_sel[1:0];
        a = (m_busy && out_ready) ? (4'b0001 << s) : 4'b0000;
        return {m_busy, m_busy, s, m_data, a};
    endfunction

    // Advance the model across one rising edge using the inputs present now.
    task automatic tick();
        bit nb; int ns, np; logic [W-1:0] nd;
        nb = m_busy; ns = m_sel; np = m_ptr; nd = m_data;
        if (!rst_n) begin
            nb = 0; ns = 0; np = 0; nd = '0;
        end else if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (req[i]) begin
                    nb = 1; ns = i; nd = d[i];
                    break;
                end
            end
        end else if (out_ready) begin
            nb = 0;
            np = (m_sel + 1) % 4;
        end
        @(posedge clk);
        #1;
        m_busy = nb; m_sel = ns; m_ptr = np; m_data = nd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [W+7:0] zero;
        zero = '0;
        rst_n = 1'b0; req = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            n_tot++;
            if (dut_vec !== zero || dut_vec !== exp_vec())
                $display("FAIL reset c%0d: got %h expected %h", c, dut_vec, zero);
            else n_pass++;
        end
        rst_n = 1'b1; req = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] a;
        req = 4'b0100; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tot++;
            if (dut_vec !== exp_vec())
                $display("FAIL single c%0d: got %h expected %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (c == 1) begin
                n_tot++;
                if (!(out_valid === 1'b1 && sel === 2'd2 && out_data === 32'd12 && ack === 4'b0100))
                    $display("FAIL single_grant: got v=%b sel=%0d data=%0d ack=%b expected v=1 sel=2 data=12 ack=0100",
                             out_valid, sel, out_data, ack);
                else n_pass++;
            end
            if (c == 2) begin
                n_tot++;
                if (out_valid !== 1'b0)
                    $display("FAIL single_drop: got out_valid=%b expected 0", out_valid);
                else n_pass++;
            end
            a = ack;
            tick();
            req = req & ~a;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words[$];
        int           when[$];
        logic [W-1:0] exp_seq[5];
        exp_seq[0] = 10; exp_seq[1] = 11; exp_seq[2] = 12; exp_seq[3] = 13; exp_seq[4] = 10;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_tot++;
            if (dut_vec !== exp_vec())
                $display("FAIL b2b c%0d: got %h expected %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (out_valid === 1'b1 && out_ready) begin
                words.push_back(out_data);
                when.push_back(c);
            end
            tick();
        end
        n_tot++;
        if (words.size() != 5)
            $display("FAIL b2b_count: got %0d transfers expected 5", words.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < words.size(); i++) begin
            n_tot++;
            if (words[i] !== exp_seq[i] || (i > 0 && when[i] - when[i-1] != 2))
                $display("FAIL b2b_seq%0d: got %0d at gap %0d expected %0d at gap 2",
                         i, words[i], (i > 0) ? when[i] - when[i-1] : 2, exp_seq[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic [3:0] a;
        req = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            out_ready = (c >= 6);
            if (c == 3) begin
                d[1] = 32'hBAD;
                req  = 4'b0000;
            end
            @(negedge clk);
            n_tot++;
            if (dut_vec !== exp_vec())
                $display("FAIL stall c%0d: got %h expected %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (c >= 1 && c <= 5) begin
                n_tot++;
                if (!(out_valid === 1'b1 && out_data === 32'd11 && ack === 4'b0000))
                    $display("FAIL stall_hold c%0d: got v=%b data=%0d ack=%b expected v=1 data=11 ack=0000",
                             c, out_valid, out_data, ack);
                else n_pass++;
            end
            if (c == 6) begin
                n_tot++;
                if (ack !== 4'b0010)
                    $display("FAIL stall_ack: got %b expected 0010", ack);
                else n_pass++;
            end
            a = ack;
            tick();
            req = req & ~a;
        end
        d[1] = 32'd11;
        req  = 4'b0000;
    endtask

    task automatic test_wrap();
        logic [3:0]   a;
        logic [W-1:0] got[$];
        do_reset();
        req = 4'b0100; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req = 4'b1001;
            @(negedge clk);
            n_tot++;
            if (dut_vec !== exp_vec())
                $display("FAIL wrap c%0d: got %h expected %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (ack !== 4'b0000) got.push_back(out_data);
            a = ack;
            tick();
            req = req & ~a;
        end
        n_tot++;
        if (got.size() != 3 || got[0] !== 32'd12 || got[1] !== 32'd13 || got[2] !== 32'd10)
            $display("FAIL wrap_order: got %0d words first=%0d expected 12,13,10",
                     got.size(), (got.size() > 0) ? got[0] : 0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        req = 4'b0010; out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) rst_n = 1'b0;
            if (c == 4) begin
                rst_n = 1'b1; req = 4'b1111; out_ready = 1'b1;
            end
            @(negedge clk);
            n_tot++;
            if (dut_vec !== exp_vec())
                $display("FAIL rstmid c%0d: got %h expected %h", c, dut_vec, exp_vec());
            else n_pass++;
            if (c == 3) begin
                n_tot++;
                if (out_valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0)
                    $display("FAIL rstmid_drop: got v=%b ack=%b busy=%b expected 0/0000/0", out_valid, ack, busy);
                else n_pass++;
            end
            if (c == 5) begin
                n_tot++;
                if (sel !== 2'd0 || out_data !== 32'd10 || ack !== 4'b0001)
                    $display("FAIL rstmid_first: got sel=%0d data=%0d ack=%b expected 0/10/0001", sel, out_data, ack);
                else n_pass++;
            end
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_random();
        logic [3:0] a;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && ($urandom % 3 == 0)) begin
                    req[i] = 1'b1;
                    d[i]   = $urandom;
                end
            end
            out_ready = ($urandom % 4 != 0);
            @(negedge clk);
            n_tot++;
            if (dut_vec !== exp_vec())
                $display("FAIL random c%0d: got %h expected %h", c, dut_vec, exp_vec());
            else n_pass++;
            a = ack;
            tick();
            req = req & ~a;
        end
    endtask

    initial begin
        d[0] = 32'd10; d[1] = 32'd11; d[2] = 32'd12; d[3] = 32'd13;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_reset_mid_send();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
